cmem_loader: RTL and testbench

Write-side controller for the coefficient memory. It accepts a valid/ready stream of 16-bit coefficients and writes them to consecutive addresses from 0 into all eight coefficient banks at once. While idle it passes the filter datapath's eight read addresses through to the memory. It sits between the host coefficient stream and the coefficient memory, and owns that memory's D, A7..A0, WEN and CEN pins.

---
 rtl/cmem_loader.sv | 128 ++++++++++++
 tb/tb_cmem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_loader.sv
// Streams DW-bit coefficients into all eight coefficient banks at addresses 0..n-1, one word per cycle.
// WEN trails the registered D/A by one cycle; s_ready is low outside LOAD. Idle cycles pass the read addresses through.
module cmem_loader #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   num_coef,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic [AW-1:0] rd_addr3,
    input  logic [AW-1:0] rd_addr4,
    input  logic [AW-1:0] rd_addr5,
    input  logic [AW-1:0] rd_addr6,
    input  logic [AW-1:0] rd_addr7,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] D,
    output logic [AW-1:0] A0,
    output logic [AW-1:0] A1,
    output logic [AW-1:0] A2,
    output logic [AW-1:0] A3,
    output logic [AW-1:0] A4,
    output logic [AW-1:0] A5,
    output logic [AW-1:0] A6,
    output logic [AW-1:0] A7,
    output logic          WEN,
    output logic          CEN
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   n_q, n_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          acc_q, acc_d;
    logic          wen_q, cen_q, done_q;
    logic          hs;
    logic [AW:0]   idx_inc;
    logic          idle;

    assign idle    = (state_q == IDLE);
    assign s_ready = (state_q == LOAD) && (idx_q < n_q);
    assign hs      = s_valid && s_ready;
    assign idx_inc = idx_q + (AW+1)'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        data_d  = data_q;
        waddr_d = waddr_q;
        acc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    n_d     = (num_coef == '0 || num_coef > DEPTH) ? DEPTH : num_coef;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    data_d  = s_data;
                    waddr_d = idx_q[AW-1:0];
                    idx_d   = idx_inc;
                    acc_d   = 1'b1;
                    if (idx_inc == n_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The memory registers D/A itself and samples WEN raw, so WEN lags the accept by one extra cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            data_q  <= '0;
            waddr_q <= '0;
            acc_q   <= 1'b0;
            wen_q   <= OFF;
            cen_q   <= OFF;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            data_q  <= data_d;
            waddr_q <= waddr_d;
            acc_q   <= acc_d;
            wen_q   <= acc_q ? ON : OFF;
            cen_q   <= ON;
            done_q  <= (state_q == FLUSH);
        end
    end

    assign busy = !idle;
    assign done = done_q;
    assign D    = data_q;
    assign WEN  = wen_q;
    assign CEN  = cen_q;

    assign A0 = idle ? rd_addr0 : waddr_q;
    assign A1 = idle ? rd_addr1 : waddr_q;
    assign A2 = idle ? rd_addr2 : waddr_q;
    assign A3 = idle ? rd_addr3 : waddr_q;
    assign A4 = idle ? rd_addr4 : waddr_q;
    assign A5 = idle ? rd_addr5 : waddr_q;
    assign A6 = idle ? rd_addr6 : waddr_q;
    assign A7 = idle ? rd_addr7 : waddr_q;
endmodule

// File: tb/tb_cmem_loader.sv
// Bench for cmem_loader: eight-bank memory model on the D/A/WEN/CEN pins plus a cycle-level load model.
module tb_cmem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  num_coef = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic [5:0]  rd [8];
    logic        busy, done;
    logic [15:0] D;
    logic [5:0]  a_o [8];
    logic        WEN, CEN;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    cmem_loader #(.DW(16), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_coef(num_coef),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rd_addr0(rd[0]), .rd_addr1(rd[1]), .rd_addr2(rd[2]), .rd_addr3(rd[3]),
        .rd_addr4(rd[4]), .rd_addr5(rd[5]), .rd_addr6(rd[6]), .rd_addr7(rd[7]),
        .busy(busy), .done(done), .D(D),
        .A0(a_o[0]), .A1(a_o[1]), .A2(a_o[2]), .A3(a_o[3]),
        .A4(a_o[4]), .A5(a_o[5]), .A6(a_o[6]), .A7(a_o[7]),
        .WEN(WEN), .CEN(CEN)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory: D/A captured on the rising edge, array write on the falling edge when WEN and CEN are low.
    logic [15:0] mem [8][64];
    logic [15:0] d_r;
    logic [5:0]  a_r [8];
    always @(posedge clk) begin
        d_r <= D;
        for (int b = 0; b < 8; b++) a_r[b] <= a_o[b];
    end
    always @(negedge clk) begin
        if (WEN == 1'b0 && CEN == 1'b0)
            for (int b = 0; b < 8; b++) mem[b][a_r[b]] <= d_r;
    end

    // Reference: what the loader should be doing, tracked as phase/count plus the two-cycle write delay.
    logic [15:0] exp_mem [64];
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_n = 0;
    bit          m_hs = 0, hs1 = 0, hs2 = 0, m_done = 0, m_cen_on = 0;
    logic [15:0] m_d = '0, w1_d = '0;
    logic [5:0]  m_a = '0, w1_a = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_n = 0; m_hs = 0; hs1 = 0; hs2 = 0;
            m_done = 0; m_cen_on = 0; m_d = '0; m_a = '0;
        end else begin
            m_hs = (m_phase == 1) && (m_cnt < m_n) && s_valid;
            if (hs1) exp_mem[w1_a] = w1_d;
            hs2 = hs1;
            hs1 = m_hs;
            m_cen_on = 1;
            m_done = (m_phase == 2);
            if (m_hs) begin
                w1_a = 6'(m_cnt); w1_d = s_data; m_a = 6'(m_cnt); m_d = s_data;
            end
            case (m_phase)
                0: if (start) begin
                       m_phase = 1; m_cnt = 0;
                       m_n = (num_coef == 0 || num_coef > 64) ? 64 : int'(num_coef);
                   end
                1: if (m_hs) begin
                       m_cnt++;
                       if (m_cnt == m_n) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("s_ready", s_ready, (m_phase == 1) && (m_cnt < m_n));
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_done);
            chk("wen", WEN, hs2 ? 1'b0 : 1'b1);
            chk("cen", CEN, m_cen_on ? 1'b0 : 1'b1);
            chk("d", D, m_d);
            for (int b = 0; b < 8; b++)
                chk("addr", a_o[b], (m_phase == 0) ? rd[b] : m_a);
            if (done) done_cnt++;
        end
    end

    task automatic run_load(input logic [6:0] nc, input int gap_pct, input logic [15:0] base,
                            input int restart_at);
        int nexp, sent, cyc;
        nexp = (nc == 0 || nc > 64) ? 64 : int'(nc);
        done_cnt = 0;
        start = 1'b1; num_coef = nc; s_valid = 1'b1; s_data = base;
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0; cyc = 0;
        while (sent < nexp && cyc < 1000) begin
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = base + 16'(sent);
            if (cyc == restart_at) begin start = 1'b1; num_coef = 7'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (m_hs) sent++;
        end
        start = 1'b0; s_valid = 1'b0;
        chk("load_count", sent, nexp);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 1);
    endtask

    task automatic readback();
        for (int base = 0; base < 64; base += 8) begin
            for (int b = 0; b < 8; b++) rd[b] = 6'(base + ((b + base / 8) % 8));
            @(posedge clk); #1;
            for (int b = 0; b < 8; b++)
                chk("readback", mem[b][a_r[b]], exp_mem[a_r[b]]);
        end
    endtask

    initial begin
        int sent, cyc;
        logic [6:0] pat;
        for (int b = 0; b < 8; b++) rd[b] = '0;
        for (int i = 0; i < 64; i++) begin
            exp_mem[i] = 16'hDEAD;
            for (int b = 0; b < 8; b++) mem[b][i] = 16'hDEAD;
        end

        // Reset held for three cycles.
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", WEN, 1'b1);
        chk("rst_cen", CEN, 1'b1);
        chk("rst_d", D, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("cen_on", CEN, 1'b0);

        // Pass-through while idle.
        for (int b = 0; b < 8; b++) rd[b] = 6'(b * 7);
        #1;
        for (int b = 0; b < 8; b++) chk("pass", a_o[b], 32'(b * 7));
        repeat (4) begin
            @(posedge clk); #1;
            for (int b = 0; b < 8; b++) rd[b] = 6'($urandom_range(0, 63));
        end

        // Full 64-word load, no gaps.
        run_load(7'd0, 0, 16'h1000, -1);
        readback();

        // Five words with a fixed valid pattern 1,0,1,1,0,1,1.
        done_cnt = 0;
        start = 1'b1; num_coef = 7'd5; s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        pat = 7'b1101101;
        sent = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid = pat[i];
            s_data = 16'h2000 + 16'(sent);
            @(posedge clk); #1;
            if (m_hs) sent++;
        end
        chk("gap_count", sent, 5);
        s_valid = 1'b1; s_data = 16'hBAD0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("gap_done", done_cnt, 1);
        readback();

        // start again while busy must be ignored.
        run_load(7'd8, 20, 16'h3000, 3);
        readback();

        // Random loads, including counts above the depth.
        for (int t = 0; t < 4; t++)
            run_load(7'($urandom_range(0, 127)), 30, 16'($urandom), -1);
        run_load(7'd100, 10, 16'h1000, -1);
        readback();

        // Reset one cycle after word 10 is accepted.
        start = 1'b1; num_coef = 7'd20; s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1;
        sent = 0; cyc = 0;
        while (sent < 11 && cyc < 100) begin
            s_data = 16'h5000 + 16'(sent);
            @(posedge clk); #1;
            cyc++;
            if (m_hs) sent++;
        end
        chk("rst_mid_count", sent, 11);
        rst_n = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("addr9_written", mem[0][9], 16'h5009);
        chk("addr10_kept", mem[0][10], 16'h100A);
        readback();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
